// File: rtl/readout_rx_bin_decision.sv
// Decision stage behind the readout bin accumulator: arms it, counts a sample window,
// thresholds the final count into a qubit state. Optional erasure flag: READOUT_RX_DECISION_ERASURE_EN.
module readout_rx_bin_decision #(
   parameter int BIN_COUNTER_WIDTH = 16,
   parameter int WINDOW_LEN_WIDTH  = 12
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_readout,
   input  logic [WINDOW_LEN_WIDTH-1:0]  window_len,
   input  logic [BIN_COUNTER_WIDTH-1:0] threshold,
   input  logic                         sample_valid,
   input  logic [BIN_COUNTER_WIDTH-1:0] bin_count_in,
`ifdef READOUT_RX_DECISION_ERASURE_EN
   input  logic [BIN_COUNTER_WIDTH-1:0] margin,
   output logic                         result_erasure,
`endif
   output logic                         acc_start_count,
   output logic                         acc_valid_in,
   output logic                         busy,
   output logic                         result_valid,
   input  logic                         result_ready,
   output logic                         result_state,
   output logic [BIN_COUNTER_WIDTH-1:0] result_count,
   output logic                         overrun
);

   localparam int BCW = BIN_COUNTER_WIDTH;
   localparam int WLW = WINDOW_LEN_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_COUNT  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_OUT    = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WLW-1:0]   len_r;
   logic [WLW-1:0]   cnt_r;
   logic             last_sample_s;
   logic             acc_start_count_r;
   logic             busy_r;
   logic             result_valid_r;
   logic             result_state_r;
   logic [BCW-1:0]   result_count_r;
   logic             overrun_r;

`ifdef READOUT_RX_DECISION_ERASURE_EN
   logic             result_erasure_r;

   // Distance |count - threshold| is formed one bit wider so neither direction wraps.
   function automatic logic within_margin(input logic [BCW-1:0] count,
                                          input logic [BCW-1:0] thr,
                                          input logic [BCW-1:0] mrg);
      logic [BCW:0] diff;
      logic [BCW:0] dist;
      diff = {1'b0, count} - {1'b0, thr};
      if (diff[BCW]) begin
         dist = ~diff + {{BCW{1'b0}}, 1'b1};
      end else begin
         dist = diff;
      end
      return (dist < {1'b0, mrg});
   endfunction
`endif

   assign last_sample_s = sample_valid && ((cnt_r + {{(WLW-1){1'b0}}, 1'b1}) == len_r);

   // Next-state logic for the integration window sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_readout) begin
               state_s = ST_ARM;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (len_r == {WLW{1'b0}}) begin
               state_s = ST_SETTLE;
            end else begin
               state_s = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (last_sample_s) begin
               state_s = ST_SETTLE;
            end else begin
               state_s = ST_COUNT;
            end
         end
         ST_SETTLE: state_s = ST_OUT;
         ST_OUT: begin
            if (result_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_OUT;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register, window bookkeeping, result capture and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r           <= ST_IDLE;
         len_r             <= {WLW{1'b0}};
         cnt_r             <= {WLW{1'b0}};
         acc_start_count_r <= 1'b0;
         busy_r            <= 1'b0;
         result_valid_r    <= 1'b0;
         result_state_r    <= 1'b0;
         result_count_r    <= {BCW{1'b0}};
         overrun_r         <= 1'b0;
`ifdef READOUT_RX_DECISION_ERASURE_EN
         result_erasure_r  <= 1'b0;
`endif
      end else begin
         state_r           <= state_s;
         // Status flags are decoded from the next state so they align with state_r.
         acc_start_count_r <= (state_s == ST_ARM);
         busy_r            <= (state_s != ST_IDLE);
         result_valid_r    <= (state_s == ST_OUT);

         if ((state_r == ST_IDLE) && start_readout) begin
            len_r <= window_len;
            cnt_r <= {WLW{1'b0}};
         end else if ((state_r == ST_COUNT) && sample_valid) begin
            cnt_r <= cnt_r + {{(WLW-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end

         if (state_r == ST_SETTLE) begin
            result_count_r   <= bin_count_in;
            result_state_r   <= (bin_count_in >= threshold);
`ifdef READOUT_RX_DECISION_ERASURE_EN
            result_erasure_r <= within_margin(bin_count_in, threshold, margin);
`endif
         end

         if (start_readout && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
         end
      end
   end

   assign acc_valid_in    = (state_r == ST_COUNT) && sample_valid;
   assign acc_start_count = acc_start_count_r;
   assign busy            = busy_r;
   assign result_valid    = result_valid_r;
   assign result_state    = result_state_r;
   assign result_count    = result_count_r;
   assign overrun         = overrun_r;
`ifdef READOUT_RX_DECISION_ERASURE_EN
   assign result_erasure  = result_erasure_r;
`endif

endmodule
